// File: rtl/lnl_io_unit.sv
// Keyboard/display I/O controller for the LnL accumulator CPU: input FIFO, output handshake, IEN/IRQ.
// Optional macro LNL_IO_IRQ_MASK_EN adds a software-writable per-source interrupt mask.
module lnl_io_unit #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IN_DEPTH = 4,
    localparam int unsigned LVL_W   = $clog2(IN_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] kbd_data,
    input  logic              kbd_stb,
    input  logic              cpu_inp,
    input  logic              cpu_out,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_ion,
    input  logic              cpu_iof,
    input  logic              cpu_iack,
    input  logic              cpu_clr_err,
`ifdef LNL_IO_IRQ_MASK_EN
    input  logic              cpu_imask_wr,
    input  logic [1:0]        cpu_imask,
`endif
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              fgi,
    output logic              fgo,
    output logic              ien,
    output logic              irq,
    output logic              ovf,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              disp_ack
);

    localparam int unsigned PTR_W = $clog2(IN_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

    logic [DATA_W-1:0] mem_q [IN_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d, ien_q, ien_d, irq_q, irq_d;
    logic              fgo_q, fgo_d, disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    state_e            state_q, state_d;
    logic              full, pop_ok, push_ok;
    logic              m_in, m_out;

`ifdef LNL_IO_IRQ_MASK_EN
    logic [1:0] mask_q, mask_d;

    always_comb begin
        mask_d = cpu_imask_wr ? cpu_imask : mask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= 2'b11;
        else        mask_q <= mask_d;
    end

    assign m_in  = mask_d[0];
    assign m_out = mask_d[1];
`else
    assign m_in  = 1'b1;
    assign m_out = 1'b1;
`endif

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    always_comb begin
        full     = (level_q == LVL_W'(IN_DEPTH));
        pop_ok   = cpu_inp && (level_q != '0);
        push_ok  = kbd_stb && (!full || pop_ok);
        ovf_d    = (ovf_q && !cpu_clr_err) || (kbd_stb && full && !pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);

        state_d     = state_q;
        disp_data_d = disp_data_q;
        unique case (state_q)
            IDLE: if (cpu_out) begin
                state_d     = BUSY;
                disp_data_d = cpu_wdata;
            end
            BUSY: if (disp_ack) state_d = IDLE;
        endcase
        fgo_d        = (state_d == IDLE);
        disp_valid_d = (state_d == BUSY);

        ien_d = ien_q;
        if (cpu_iack)     ien_d = 1'b0;
        else if (cpu_iof) ien_d = 1'b0;
        else if (cpu_ion) ien_d = 1'b1;

        // Built from next-state flags so irq asserts alongside the flag that causes it.
        irq_d = ien_d && (((level_d != '0) && m_in) || (fgo_d && m_out));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            ovf_q        <= 1'b0;
            ien_q        <= 1'b0;
            irq_q        <= 1'b0;
            fgo_q        <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            state_q      <= IDLE;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            ovf_q        <= ovf_d;
            ien_q        <= ien_d;
            irq_q        <= irq_d;
            fgo_q        <= fgo_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            state_q      <= state_d;
        end
    end

    // Storage is deliberately not reset; the level counter alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= kbd_data;
    end

    assign cpu_rdata  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fgi        = (level_q != '0);
    assign fifo_level = level_q;
    assign fgo        = fgo_q;
    assign ien        = ien_q;
    assign irq        = irq_q;
    assign ovf        = ovf_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_lnl_io_unit.sv
// Scoreboard bench for lnl_io_unit (default DATA_W=8, IN_DEPTH=4); mask test runs when LNL_IO_IRQ_MASK_EN is defined.
module tb_lnl_io_unit;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] kbd_data, cpu_wdata, cpu_rdata, disp_data;
    logic       kbd_stb, cpu_inp, cpu_out, cpu_ion, cpu_iof, cpu_iack, cpu_clr_err, disp_ack;
    logic       fgi, fgo, ien, irq, ovf, disp_valid;
    logic [2:0] fifo_level;
`ifdef LNL_IO_IRQ_MASK_EN
    logic       cpu_imask_wr;
    logic [1:0] cpu_imask;
`endif

    int         ntests = 0;
    int         nfail  = 0;
    logic [7:0] sb[$];
    logic [7:0] dq[$];
    logic       exp_ovf;
    logic [7:0] exp;

    lnl_io_unit dut (
        .clk(clk), .rst_n(rst_n), .kbd_data(kbd_data), .kbd_stb(kbd_stb),
        .cpu_inp(cpu_inp), .cpu_out(cpu_out), .cpu_wdata(cpu_wdata),
        .cpu_ion(cpu_ion), .cpu_iof(cpu_iof), .cpu_iack(cpu_iack), .cpu_clr_err(cpu_clr_err),
`ifdef LNL_IO_IRQ_MASK_EN
        .cpu_imask_wr(cpu_imask_wr), .cpu_imask(cpu_imask),
`endif
        .cpu_rdata(cpu_rdata), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq), .ovf(ovf),
        .fifo_level(fifo_level), .disp_data(disp_data), .disp_valid(disp_valid), .disp_ack(disp_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", ntests, nfail);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one keyboard strobe and record what the reference FIFO expects.
    task automatic push(input logic [7:0] d);
        kbd_data = d; kbd_stb = 1'b1;
        if (sb.size() < DEPTH) sb.push_back(d);
        else exp_ovf = 1'b1;
        tick();
        kbd_stb = 1'b0;
    endtask

    task automatic pulse_inp();
        cpu_inp = 1'b1; tick(); cpu_inp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        ntests++; if (fgi !== 1'b0) begin nfail++; $display("FAIL reset_fgi got=%0h exp=0", fgi); end
        ntests++; if (fgo !== 1'b1) begin nfail++; $display("FAIL reset_fgo got=%0h exp=1", fgo); end
        ntests++; if (ien !== 1'b0) begin nfail++; $display("FAIL reset_ien got=%0h exp=0", ien); end
        ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL reset_irq got=%0h exp=0", irq); end
        ntests++; if (ovf !== 1'b0) begin nfail++; $display("FAIL reset_ovf got=%0h exp=0", ovf); end
        ntests++; if (disp_valid !== 1'b0) begin nfail++; $display("FAIL reset_disp_valid got=%0h exp=0", disp_valid); end
        ntests++; if (disp_data !== 8'h00) begin nfail++; $display("FAIL reset_disp_data got=%0h exp=0", disp_data); end
        ntests++; if (fifo_level !== 3'd0) begin nfail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        ntests++; if (cpu_rdata !== 8'h00) begin nfail++; $display("FAIL reset_rdata got=%0h exp=0", cpu_rdata); end
    endtask

    task automatic test_fifo_order();
        logic [7:0] pat [3] = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) begin
            push(pat[i]);
            ntests++; if (fifo_level !== 3'(i + 1)) begin nfail++; $display("FAIL order_level_up got=%0d exp=%0d", fifo_level, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            ntests++; if (fifo_level !== 3'(sb.size())) begin nfail++; $display("FAIL order_level_dn got=%0d exp=%0d", fifo_level, sb.size()); end
            exp = sb.pop_front();
            ntests++; if (cpu_rdata !== exp) begin nfail++; $display("FAIL order_rdata got=%0h exp=%0h", cpu_rdata, exp); end
            pulse_inp();
        end
        ntests++; if (fgi !== 1'b0) begin nfail++; $display("FAIL order_fgi_end got=%0h exp=0", fgi); end
        ntests++; if (cpu_rdata !== 8'h00) begin nfail++; $display("FAIL order_rdata_empty got=%0h exp=0", cpu_rdata); end
        pulse_inp();
        ntests++; if (fifo_level !== 3'd0) begin nfail++; $display("FAIL empty_inp_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
        ntests++; if (fifo_level !== 3'd4) begin nfail++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
        ntests++; if (ovf !== exp_ovf) begin nfail++; $display("FAIL ovf_set got=%0h exp=%0h", ovf, exp_ovf); end
        for (int i = 0; i < 4; i++) begin
            exp = sb.pop_front();
            ntests++; if (cpu_rdata !== exp) begin nfail++; $display("FAIL ovf_rdata got=%0h exp=%0h", cpu_rdata, exp); end
            pulse_inp();
        end
        ntests++; if (ovf !== 1'b1) begin nfail++; $display("FAIL ovf_sticky got=%0h exp=1", ovf); end
        cpu_clr_err = 1'b1; tick(); cpu_clr_err = 1'b0; exp_ovf = 1'b0;
        ntests++; if (ovf !== 1'b0) begin nfail++; $display("FAIL ovf_clr got=%0h exp=0", ovf); end
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        // Full with simultaneous push and pop: both must happen.
        exp = sb.pop_front();
        ntests++; if (cpu_rdata !== exp) begin nfail++; $display("FAIL full_sim_rdata got=%0h exp=%0h", cpu_rdata, exp); end
        kbd_data = 8'h54; kbd_stb = 1'b1; cpu_inp = 1'b1; sb.push_back(8'h54);
        tick();
        kbd_stb = 1'b0; cpu_inp = 1'b0;
        ntests++; if (fifo_level !== 3'd4) begin nfail++; $display("FAIL full_sim_level got=%0d exp=4", fifo_level); end
        ntests++; if (ovf !== 1'b0) begin nfail++; $display("FAIL full_sim_ovf got=%0h exp=0", ovf); end
        // Clear and new overflow together: set wins, contents untouched.
        kbd_data = 8'h99; kbd_stb = 1'b1; cpu_clr_err = 1'b1;
        tick();
        kbd_stb = 1'b0; cpu_clr_err = 1'b0;
        ntests++; if (ovf !== 1'b1) begin nfail++; $display("FAIL ovf_set_wins got=%0h exp=1", ovf); end
        cpu_clr_err = 1'b1; tick(); cpu_clr_err = 1'b0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            ntests++; if (cpu_rdata !== exp) begin nfail++; $display("FAIL drain_rdata got=%0h exp=%0h", cpu_rdata, exp); end
            pulse_inp();
        end
        // Empty with simultaneous push and pop: only the push lands.
        kbd_data = 8'h77; kbd_stb = 1'b1; cpu_inp = 1'b1; sb.push_back(8'h77);
        tick();
        kbd_stb = 1'b0; cpu_inp = 1'b0;
        ntests++; if (fifo_level !== 3'd1) begin nfail++; $display("FAIL empty_sim_level got=%0d exp=1", fifo_level); end
        exp = sb.pop_front();
        ntests++; if (cpu_rdata !== exp) begin nfail++; $display("FAIL empty_sim_rdata got=%0h exp=%0h", cpu_rdata, exp); end
        pulse_inp();
        ntests++; if (fifo_level !== 3'd0) begin nfail++; $display("FAIL empty_sim_drain got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_display();
        cpu_wdata = 8'h5A; cpu_out = 1'b1; dq.push_back(8'h5A); tick(); cpu_out = 1'b0;
        ntests++; if (disp_valid !== 1'b1) begin nfail++; $display("FAIL disp_valid_set got=%0h exp=1", disp_valid); end
        ntests++; if (fgo !== 1'b0) begin nfail++; $display("FAIL disp_fgo_busy got=%0h exp=0", fgo); end
        cpu_wdata = 8'h11; cpu_out = 1'b1; tick(); cpu_out = 1'b0;
        exp = dq.pop_front();
        ntests++; if (disp_data !== exp) begin nfail++; $display("FAIL disp_hold got=%0h exp=%0h", disp_data, exp); end
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        ntests++; if (fgo !== 1'b1) begin nfail++; $display("FAIL disp_ack_fgo got=%0h exp=1", fgo); end
        ntests++; if (disp_valid !== 1'b0) begin nfail++; $display("FAIL disp_ack_valid got=%0h exp=0", disp_valid); end
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        ntests++; if (fgo !== 1'b1 || disp_valid !== 1'b0) begin nfail++; $display("FAIL disp_idle_ack got=%0h%0h exp=10", fgo, disp_valid); end
        // Back to back: acknowledge then immediately load the next character.
        cpu_wdata = 8'h22; cpu_out = 1'b1; dq.push_back(8'h22); tick(); cpu_out = 1'b0;
        exp = dq.pop_front();
        ntests++; if (disp_data !== exp) begin nfail++; $display("FAIL b2b_first got=%0h exp=%0h", disp_data, exp); end
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        cpu_wdata = 8'h33; cpu_out = 1'b1; dq.push_back(8'h33); tick(); cpu_out = 1'b0;
        exp = dq.pop_front();
        ntests++; if (disp_data !== exp || disp_valid !== 1'b1) begin nfail++; $display("FAIL b2b_second got=%0h/%0h exp=%0h/1", disp_data, disp_valid, exp); end
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    endtask

    task automatic test_irq();
        cpu_wdata = 8'h66; cpu_out = 1'b1; dq.push_back(8'h66); tick(); cpu_out = 1'b0;
        cpu_ion = 1'b1; tick(); cpu_ion = 1'b0;
        ntests++; if (ien !== 1'b1) begin nfail++; $display("FAIL irq_ion got=%0h exp=1", ien); end
        ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL irq_no_source got=%0h exp=0", irq); end
        push(8'h07);
        ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL irq_after_push got=%0h exp=1", irq); end
        cpu_iack = 1'b1; tick(); cpu_iack = 1'b0;
        ntests++; if (ien !== 1'b0 || irq !== 1'b0) begin nfail++; $display("FAIL irq_iack got=%0h%0h exp=00", ien, irq); end
        cpu_ion = 1'b1; cpu_iof = 1'b1; tick(); cpu_ion = 1'b0; cpu_iof = 1'b0;
        ntests++; if (ien !== 1'b0) begin nfail++; $display("FAIL irq_ion_iof got=%0h exp=0", ien); end
        cpu_ion = 1'b1; cpu_iack = 1'b1; tick(); cpu_ion = 1'b0; cpu_iack = 1'b0;
        ntests++; if (ien !== 1'b0) begin nfail++; $display("FAIL irq_ion_iack got=%0h exp=0", ien); end
        cpu_ion = 1'b1; tick(); cpu_ion = 1'b0;
        ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL irq_reenable got=%0h exp=1", irq); end
        cpu_iof = 1'b1; tick(); cpu_iof = 1'b0;
        ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL irq_iof got=%0h exp=0", irq); end
        exp = sb.pop_front();
        ntests++; if (cpu_rdata !== exp) begin nfail++; $display("FAIL irq_rdata got=%0h exp=%0h", cpu_rdata, exp); end
        pulse_inp();
        exp = dq.pop_front();
        ntests++; if (disp_data !== exp) begin nfail++; $display("FAIL irq_disp got=%0h exp=%0h", disp_data, exp); end
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    endtask

`ifdef LNL_IO_IRQ_MASK_EN
    task automatic test_mask();
        cpu_imask = 2'b01; cpu_imask_wr = 1'b1; tick(); cpu_imask_wr = 1'b0;
        cpu_ion = 1'b1; tick(); cpu_ion = 1'b0;
        ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL mask_out_off got=%0h exp=0", irq); end
        push(8'h01);
        ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL mask_in_on got=%0h exp=1", irq); end
        exp = sb.pop_front();
        pulse_inp();
        cpu_iof = 1'b1; cpu_imask = 2'b11; cpu_imask_wr = 1'b1; tick();
        cpu_iof = 1'b0; cpu_imask_wr = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        push(8'hA1);
        cpu_wdata = 8'hB2; cpu_out = 1'b1; tick(); cpu_out = 1'b0;
        cpu_ion = 1'b1; tick(); cpu_ion = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        ntests++; if (fifo_level !== 3'd0 || fgo !== 1'b1 || disp_valid !== 1'b0 || ien !== 1'b0 || disp_data !== 8'h00)
            begin nfail++; $display("FAIL async_reset got=lvl%0d fgo%0h dv%0h ien%0h dd%0h exp=lvl0 fgo1 dv0 ien0 dd0", fifo_level, fgo, disp_valid, ien, disp_data); end
        sb.delete(); dq.delete(); exp_ovf = 1'b0;
        tick(); rst_n = 1'b1; tick();
        ntests++; if (cpu_rdata !== 8'h00 || irq !== 1'b0) begin nfail++; $display("FAIL post_reset got=%0h/%0h exp=0/0", cpu_rdata, irq); end
    endtask

    initial begin
        rst_n = 1'b0; kbd_data = '0; kbd_stb = 1'b0; cpu_inp = 1'b0; cpu_out = 1'b0;
        cpu_wdata = '0; cpu_ion = 1'b0; cpu_iof = 1'b0; cpu_iack = 1'b0;
        cpu_clr_err = 1'b0; disp_ack = 1'b0; exp_ovf = 1'b0;
`ifdef LNL_IO_IRQ_MASK_EN
        cpu_imask_wr = 1'b0; cpu_imask = 2'b11;
`endif
        test_reset();
        test_fifo_order();
        test_overflow();
        test_display();
        test_irq();
`ifdef LNL_IO_IRQ_MASK_EN
        test_mask();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
